// File: rtl/noise_gate_pkg.sv
// rtl/noise_gate_pkg.sv - shared widths, gate state encoding and gain helper
package noise_gate_pkg;

  localparam int SAMPLE_W = 32;
  localparam int GAIN_W   = 9;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    ATTACK  = 3'd1,
    OPEN    = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } gate_state_t;

  // Q1.8 gain: 41-bit signed product, arithmetic shift, truncate to sample width
  function automatic logic [SAMPLE_W-1:0] apply_gain(input logic [SAMPLE_W-1:0] s,
                                                     input logic [GAIN_W-1:0] g);
    logic signed [40:0] prod;
    prod = $signed({{9{s[SAMPLE_W-1]}}, s}) * $signed({32'd0, g});
    return SAMPLE_W'(prod >>> 8);
  endfunction

endpackage

// File: rtl/noise_gate_if.sv
// rtl/noise_gate_if.sv - stereo sample stream into and out of the noise gate
interface noise_gate_if;
  import noise_gate_pkg::*;

  logic                sample_valid;
  logic [SAMPLE_W-1:0] left_channel_audio_in;
  logic [SAMPLE_W-1:0] right_channel_audio_in;
  logic [SAMPLE_W-1:0] left_channel_audio_out;
  logic [SAMPLE_W-1:0] right_channel_audio_out;
  logic                out_valid;

  modport master (
    output sample_valid, left_channel_audio_in, right_channel_audio_in,
    input  left_channel_audio_out, right_channel_audio_out, out_valid
  );

  modport slave (
    input  sample_valid, left_channel_audio_in, right_channel_audio_in,
    output left_channel_audio_out, right_channel_audio_out, out_valid
  );

endinterface

// File: rtl/envelope_follower.sv
// rtl/envelope_follower.sv - stereo peak envelope with exponential decay
module envelope_follower
  import noise_gate_pkg::*;
#(
  parameter int ENV_DECAY_SHIFT = 10
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  output logic [30:0]         env_next
);

  logic [30:0] env;
  logic [30:0] mag_l;
  logic [30:0] mag_r;
  logic [30:0] peak;

  // Most negative sample saturates instead of wrapping to zero
  function automatic logic [30:0] magnitude(input logic [SAMPLE_W-1:0] s);
    if (s == 32'h8000_0000) return 31'h7FFF_FFFF;
    else if (s[SAMPLE_W-1]) return (~s[30:0]) + 31'd1;
    else return s[30:0];
  endfunction

  always_comb begin
    mag_l = magnitude(left_in);
    mag_r = magnitude(right_in);
    peak  = (mag_l >= mag_r) ? mag_l : mag_r;
    env_next = (peak >= env) ? peak : env - (env >> ENV_DECAY_SHIFT);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      env <= '0;
    end else if (sample_valid) begin
      env <= env_next;
    end
  end

endmodule

// File: rtl/noise_gate.sv
// rtl/noise_gate.sv - stereo noise gate: envelope-driven attack/hold/release gain
module noise_gate
  import noise_gate_pkg::*;
#(
  parameter logic [30:0] THRESH_OPEN     = 31'd46238,
  parameter logic [30:0] THRESH_CLOSE    = 31'd5395,
  parameter int          HOLD_SAMPLES    = 2400,
  parameter int          ATTACK_STEP     = 32,
  parameter int          RELEASE_STEP    = 1,
  parameter int          ENV_DECAY_SHIFT = 10
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              enable,
  noise_gate_if.slave       audio,
  output logic              gate_open,
  output logic [GAIN_W-1:0] gain
);

  localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_SAMPLES - 1);
  localparam logic [GAIN_W:0]   A_STEP    = (GAIN_W + 1)'(ATTACK_STEP);
  localparam logic [GAIN_W-1:0] R_STEP    = GAIN_W'(RELEASE_STEP);

  gate_state_t         state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [30:0]         env_next;
  logic                open_hit;
  logic                close_hit;
  logic [GAIN_W:0]     gain_sum;
  logic [GAIN_W-1:0]   gain_up;
  logic [GAIN_W-1:0]   gain_dn;
  logic                cap_valid;
  logic [SAMPLE_W-1:0] cap_l;
  logic [SAMPLE_W-1:0] cap_r;

  envelope_follower #(.ENV_DECAY_SHIFT(ENV_DECAY_SHIFT)) u_env (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .sample_valid (audio.sample_valid),
    .left_in      (audio.left_channel_audio_in),
    .right_in     (audio.right_channel_audio_in),
    .env_next     (env_next)
  );

  assign open_hit  = env_next > THRESH_OPEN;
  assign close_hit = env_next < THRESH_CLOSE;
  assign gain_sum  = {1'b0, gain} + A_STEP;
  assign gain_up   = (gain_sum > {1'b0, GAIN_UNITY}) ? GAIN_UNITY : gain_sum[GAIN_W-1:0];
  assign gain_dn   = (gain < R_STEP) ? '0 : gain - R_STEP;

  // Entering a ramp applies its first step on the same strobe
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state     <= CLOSED;
      gain      <= '0;
      hold_cnt  <= '0;
      gate_open <= 1'b0;
    end else if (audio.sample_valid) begin
      case (state)
        CLOSED: if (open_hit) begin
          gain      <= gain_up;
          state     <= (gain_up == GAIN_UNITY) ? OPEN : ATTACK;
          gate_open <= 1'b1;
        end
        ATTACK: begin
          gain <= gain_up;
          if (close_hit) begin
            state     <= RELEASE;
            gate_open <= 1'b0;
          end else if (gain_up == GAIN_UNITY) begin
            state <= OPEN;
          end
        end
        OPEN: if (close_hit) begin
          state    <= HOLD;
          hold_cnt <= HOLD_LOAD;
        end
        HOLD: begin
          if (open_hit) begin
            state <= OPEN;
          end else if (hold_cnt == '0) begin
            gain      <= gain_dn;
            state     <= (gain_dn == '0) ? CLOSED : RELEASE;
            gate_open <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        RELEASE: begin
          gain <= gain_dn;
          if (open_hit) begin
            state     <= ATTACK;
            gate_open <= 1'b1;
          end else if (gain_dn == '0) begin
            state <= CLOSED;
          end
        end
        default: begin
          state     <= CLOSED;
          gain      <= '0;
          gate_open <= 1'b0;
        end
      endcase
    end
  end

  // Capture stage, then output stage scaled by the gain updated on the strobe
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      cap_valid                     <= 1'b0;
      cap_l                         <= '0;
      cap_r                         <= '0;
      audio.out_valid               <= 1'b0;
      audio.left_channel_audio_out  <= '0;
      audio.right_channel_audio_out <= '0;
    end else begin
      cap_valid       <= audio.sample_valid;
      audio.out_valid <= cap_valid;
      if (audio.sample_valid) begin
        cap_l <= audio.left_channel_audio_in;
        cap_r <= audio.right_channel_audio_in;
      end
      if (cap_valid) begin
        audio.left_channel_audio_out  <= enable ? apply_gain(cap_l, gain) : cap_l;
        audio.right_channel_audio_out <= enable ? apply_gain(cap_r, gain) : cap_r;
      end
    end
  end

endmodule

// File: tb/tb_noise_gate.sv
// tb/tb_noise_gate.sv - randomized scoreboard bench for noise_gate
module tb_noise_gate;

  localparam int HOLD  = 4;
  localparam int SHIFT = 1;
  localparam longint TO = 46238;
  localparam longint TC = 5395;
  localparam int AS = 32;
  localparam int RS = 1;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       enable   = 1'b1;
  logic       gate_open;
  logic [8:0] gain;

  noise_gate_if bus ();

  noise_gate #(.HOLD_SAMPLES(HOLD), .ENV_DECAY_SHIFT(SHIFT)) dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .enable    (enable),
    .audio     (bus),
    .gate_open (gate_open),
    .gain      (gain)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    int          due;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  typedef enum int {M_SHUT, M_RISE, M_FULL, M_WAIT, M_FALL} m_phase_t;
  m_phase_t m_st;
  longint   m_env;
  int       m_gain;
  int       m_hold;
  bit       prev_v  = 1'b0;
  bit       prev_rn = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", name, got, want, cyc);
    end
  endtask

  function automatic longint mag(input logic [31:0] s);
    if (s == 32'h8000_0000) return 64'h7FFF_FFFF;
    return (s[31]) ? -longint'($signed(s)) : longint'(s);
  endfunction

  function automatic logic [31:0] scaled(input logic [31:0] s);
    if (!enable) return s;
    return 32'((longint'($signed(s)) * m_gain) >>> 8);
  endfunction

  function automatic void m_reset();
    m_st = M_SHUT; m_env = 0; m_gain = 0; m_hold = 0;
  endfunction

  // Gate behaviour in plain arithmetic: envelope, then ramp/hold bookkeeping
  function automatic void m_strobe(input logic [31:0] l, input logic [31:0] r);
    longint pk;
    bit loud, quiet;
    pk = (mag(l) > mag(r)) ? mag(l) : mag(r);
    m_env = (pk >= m_env) ? pk : m_env - (m_env >> SHIFT);
    loud  = m_env > TO;
    quiet = m_env < TC;
    case (m_st)
      M_SHUT: if (loud) begin
        m_gain = (m_gain + AS > 256) ? 256 : m_gain + AS;
        m_st = (m_gain == 256) ? M_FULL : M_RISE;
      end
      M_RISE: begin
        m_gain = (m_gain + AS > 256) ? 256 : m_gain + AS;
        if (quiet) m_st = M_FALL;
        else if (m_gain == 256) m_st = M_FULL;
      end
      M_FULL: if (quiet) begin m_st = M_WAIT; m_hold = HOLD - 1; end
      M_WAIT: begin
        if (loud) m_st = M_FULL;
        else if (m_hold == 0) begin
          m_gain = (m_gain - RS < 0) ? 0 : m_gain - RS;
          m_st = (m_gain == 0) ? M_SHUT : M_FALL;
        end else m_hold--;
      end
      M_FALL: begin
        m_gain = (m_gain - RS < 0) ? 0 : m_gain - RS;
        if (loud) m_st = M_RISE;
        else if (m_gain == 0) m_st = M_SHUT;
      end
      default: m_st = M_SHUT;
    endcase
  endfunction

  // One cycle: check the state produced by earlier strobes, then drive this cycle
  task automatic drive(input bit v, input logic [31:0] l, input logic [31:0] r, input bit rn);
    @(posedge CLOCK_50);
    #1;
    chk("gain", 32'(gain), 32'(m_gain));
    chk("gate_open", 32'(gate_open), 32'(m_st == M_RISE || m_st == M_FULL || m_st == M_WAIT));
    if (!prev_rn) begin
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_left_out", bus.left_channel_audio_out, 32'd0);
      chk("reset_right_out", bus.right_channel_audio_out, 32'd0);
    end
    resetn = rn;
    bus.sample_valid = v;
    bus.left_channel_audio_in = l;
    bus.right_channel_audio_in = r;
    if (!rn) begin
      if (prev_v) void'(sb.pop_back());
      m_reset();
      prev_v = 1'b0;
    end else begin
      prev_v = v;
      if (v) begin
        m_strobe(l, r);
        sb.push_back('{scaled(l), scaled(r), cyc + 2});
      end
    end
    prev_rn = rn;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 32'd0, 1'b1);
  endtask

  always @(negedge CLOCK_50) begin
    if (bus.out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.left_channel_audio_out !== e.l || bus.right_channel_audio_out !== e.r || cyc != e.due) begin
          errors++;
          $display("FAIL out_sample got L=%h R=%h cycle %0d want L=%h R=%h cycle %0d",
                   bus.left_channel_audio_out, bus.right_channel_audio_out, cyc, e.l, e.r, e.due);
        end
      end
    end
  end

  initial begin
    logic [31:0] amp;
    logic [31:0] s;
    int          kind;
    int          len;
    m_reset();
    bus.sample_valid = 1'b0;
    bus.left_channel_audio_in = '0;
    bus.right_channel_audio_in = '0;

    for (int i = 0; i < 5; i++) drive(1'b1, $urandom, $urandom, 1'b0);
    idle(3);

    for (int i = 0; i < 100; i++) drive(1'b1, 32'd1000, 32'd1000, 1'b1);
    idle(3);
    chk("quiet_gain", 32'(gain), 32'd0);

    drive(1'b1, 32'd1048576, 32'd0, 1'b1);
    idle(1);
    chk("first_attack_gain", 32'(gain), 32'd32);
    for (int i = 0; i < 7; i++) drive(1'b1, 32'd1048576, 32'd0, 1'b1);
    idle(3);
    chk("open_gain", 32'(gain), 32'd256);
    chk("open_gate", 32'(gate_open), 32'd1);

    for (int i = 0; i < 11; i++) drive(1'b1, 32'd0, 32'd0, 1'b1);
    idle(1);
    chk("hold_end_gain", 32'(gain), 32'd256);
    drive(1'b1, 32'd0, 32'd0, 1'b1);
    idle(1);
    chk("release_first_gain", 32'(gain), 32'd255);
    chk("release_gate", 32'(gate_open), 32'd0);
    for (int i = 0; i < 254; i++) drive(1'b1, 32'd0, 32'd0, 1'b1);
    idle(1);
    chk("release_last_gain", 32'(gain), 32'd1);
    drive(1'b1, 32'd0, 32'd0, 1'b1);
    idle(3);
    chk("closed_gain", 32'(gain), 32'd0);

    drive(1'b1, 32'h8000_0000, 32'd0, 1'b1);
    idle(1);
    chk("fullscale_gain", 32'(gain), 32'd32);
    drive(1'b1, 32'd0, 32'd0, 1'b1);
    idle(3);
    chk("fullscale_env_held", 32'(gain), 32'd64);

    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'(i + 100), ~32'(i), 1'b1);
      if (i >= 2) chk("burst_out_valid", 32'(bus.out_valid), 32'd1);
    end
    drive(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 32'(i + 500), 32'(i), 1'b1);
    idle(3);

    for (int seg = 0; seg < 12; seg++) begin
      enable = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 2);
      len = $urandom_range(20, 60);
      for (int i = 0; i < len; i++) begin
        case (kind)
          0: amp = $urandom_range(0, 5000);
          1: amp = $urandom_range(6000, 40000);
          default: amp = $urandom_range(50000, 32'h3FFF_FFFF);
        endcase
        s = $urandom_range(0, 1) ? -amp : amp;
        if ($urandom_range(0, 40) == 0) s = 32'h8000_0000;
        drive(1'($urandom_range(0, 3) != 0), s, $urandom_range(0, 1) ? s : ~s, 1'b1);
      end
      idle(3);
    end

    idle(4);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noise_gate.md
# noise_gate

Stereo noise gate placed directly upstream of soft_distortion. It consumes the Audio_Controller's left/right input samples on each read strobe. A peak-envelope follower and an attack/hold/release state machine produce a smoothly ramped gain, so hiss between notes is silenced before the distortion stage amplifies it. The block also reports its gate state so the top level can drive an LED or a VGA pedal indicator.

## Interface
Parameters:
- THRESH_OPEN, 31'd46238: envelope level above which the gate opens.
- THRESH_CLOSE, 31'd5395: envelope level below which the gate starts closing. Must be below THRESH_OPEN.
- HOLD_SAMPLES, 2400: strobes the gate stays fully open after the envelope drops (50 ms at 48 kHz).
- ATTACK_STEP, 32: gain increment per strobe in ATTACK.
- RELEASE_STEP, 1: gain decrement per strobe in RELEASE.
- ENV_DECAY_SHIFT, 10: envelope decays by env>>ENV_DECAY_SHIFT per strobe.

Ports:
- CLOCK_50, input, 1: sole clock.
- resetn, input, 1: synchronous, active-low reset.
- enable, input, 1: 1 applies gain; 0 passes the sample through unchanged.
- sample_valid, input, 1: one-cycle strobe; the input samples are valid in this cycle. Strobes may arrive every cycle.
- left_channel_audio_in, input, 32: signed two's-complement sample.
- right_channel_audio_in, input, 32: signed two's-complement sample.
- left_channel_audio_out, output, 32: gated sample, registered.
- right_channel_audio_out, output, 32: gated sample, registered.
- out_valid, output, 1: one-cycle pulse; the outputs are updated in this cycle.
- gate_open, output, 1: high in ATTACK, OPEN or HOLD.
- gain, output, 9: current gain in Q1.8; 256 is unity.

## Operation
Magnitude and envelope:
- Magnitude per channel is a 31-bit absolute value. 32'h80000000 saturates to 31'h7FFFFFFF, never 0.
- peak = max(absL, absR).
- On each strobe: env_next = peak if peak >= env, else env - (env >> ENV_DECAY_SHIFT). env is 31-bit unsigned.

State machine. All decisions are made on strobes only, comparing against env_next.
- CLOSED, gain 0: env_next > THRESH_OPEN → ATTACK.
- ATTACK: gain = min(gain + ATTACK_STEP, 256).
  - New gain == 256 → OPEN.
  - env_next < THRESH_CLOSE → RELEASE. This check has priority over the OPEN transition.
- OPEN, gain 256: env_next < THRESH_CLOSE → HOLD, and the hold counter loads HOLD_SAMPLES-1.
- HOLD: env_next > THRESH_OPEN → OPEN. Otherwise, counter == 0 → RELEASE; else the counter decrements.
- RELEASE: gain = max(gain - RELEASE_STEP, 0).
  - env_next > THRESH_OPEN → ATTACK.
  - New gain == 0 → CLOSED.
- Envelope between the two thresholds: the state is unchanged (hysteresis). ATTACK and RELEASE ramps continue.

Output and bypass:
- Output = (sample × gain) >>> 8, using a signed 41-bit product with arithmetic shift, truncated to 32 bits.
- Gain 256 reproduces the input exactly. Gain 0 gives 0.
- enable=0: outputs equal the captured input with the same latency. The envelope and FSM keep running.

## Timing
- Reset values: all outputs 0, out_valid 0, gate_open 0, gain 0. Internally: state CLOSED, env 0, hold counter 0.
- Strobe in cycle N, at the end-of-N edge:
  - input samples captured;
  - env, state, gain and counter updated.
- At the end-of-(N+1) edge: outputs are registered using the updated gain.
- out_valid is high during cycle N+2. Latency is 2 cycles and throughput is 1 sample per cycle.
- Back-to-back strobes produce back-to-back out_valid pulses with no drops.
- No strobe: all state holds and out_valid = 0.
- Reset during operation: an in-flight sample is discarded and no out_valid is emitted for it. All registers take their reset values at that edge.
- A change of enable takes effect for the sample whose output is registered in the same cycle.

## Structure
- Package noise_gate_pkg holds:
  - the state encoding (CLOSED, ATTACK, OPEN, HOLD, RELEASE; 3 bits);
  - GAIN_W=9 and GAIN_UNITY=9'd256;
  - SAMPLE_W=32.
- Sub-module envelope_follower holds the saturating abs, the stereo max and the decay register. It outputs env_next combinationally.
- The FSM, gain ramp, hold counter and output multiply/registers live in noise_gate.

## Test plan
- Reset: hold resetn=0 with strobes active → all outputs 0, gain 0, gate_open 0; release reset → no out_valid until 2 cycles after the first strobe.
- Below threshold, enable=1: 100 strobes with L=R=1000 → every output 0, gate_open 0, state CLOSED.
- Open ramp:
  - One strobe with L=1048576, R=0 → ATTACK, gain 32; out_valid 2 cycles later with L_out=131072.
  - After 8 such strobes → OPEN, gain 256, L_out=1048576.
- Hold and release, run with ENV_DECAY_SHIFT=1 and HOLD_SAMPLES=4. After OPEN, drive zeros:
  - the gate enters HOLD on the first strobe with env_next < 5395;
  - it stays at gain 256 for exactly 4 strobes;
  - then gain drops by 1 per strobe and reaches CLOSED after 256 strobes.
- Full-scale negative, while in ATTACK at gain 32: L=32'h80000000 → no magnitude wrap (env=31'h7FFFFFFF) and L_out=32'hF0000000.
- Bypass and throughput, enable=0, strobes every cycle with incrementing samples → each output equals its input 2 cycles later and out_valid stays high continuously. Asserting resetn=0 for one cycle drops the 2 in-flight samples.
